// File: rtl/pixel_row_readout.sv
// Serialises one parallel pixel row into a tagged show-ahead FIFO (sof/eol) with a valid/ready output.
// Rows arriving while a row is still being shifted out are dropped and flagged with a sticky overflow.
module pixel_row_readout #(
  parameter int PIX_BITS   = 8,
  parameter int COLS       = 2,
  parameter int ROWS       = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     row_valid,
  input  logic [RW-1:0]            row_sel,
  input  logic [COLS*PIX_BITS-1:0] row_data,
  output logic                     row_ready,
  output logic [PIX_BITS-1:0]      out_data,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW:0]              fifo_count,
  output logic                     overflow
);

  localparam int EW = PIX_BITS + 2;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                     r_state;
  logic                       r_row_ready;
  logic [COLS*PIX_BITS-1:0]   r_shift;
  logic                       r_row0;
  logic [CW-1:0]              r_col;
  logic                       r_overflow;
  logic [EW-1:0]              r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [AW:0]                r_count;

  logic                       w_full;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_last;
  logic                       w_sof;
  logic                       w_eol;
  logic [EW-1:0]              w_head;

  // Full uses the registered count so a pop never frees a slot for a same-cycle push.
  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_push = (r_state == S_SHIFT) && !w_full;
  assign w_pop  = out_valid && out_ready;
  assign w_last = (r_col == CW'(COLS - 1));
  assign w_sof  = r_row0 && (r_col == '0);
  assign w_eol  = w_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_row_ready <= 1'b1;
      r_shift     <= '0;
      r_row0      <= 1'b0;
      r_col       <= '0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      // A drop in the same cycle as frame_start leaves the flag set.
      if (row_valid && !r_row_ready) begin
        r_overflow <= 1'b1;
      end else if (frame_start) begin
        r_overflow <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (row_valid) begin
            r_shift     <= row_data;
            r_row0      <= (row_sel == '0);
            r_col       <= '0;
            r_state     <= S_SHIFT;
            r_row_ready <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_push) begin
            r_shift <= r_shift >> PIX_BITS;
            if (w_last) begin
              r_col       <= '0;
              r_state     <= S_IDLE;
              r_row_ready <= 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_row_ready <= 1'b1;
        end
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= {w_sof, w_eol, r_shift[PIX_BITS-1:0]};
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? w_head[PIX_BITS-1:0] : '0;
  assign out_eol    = out_valid ? w_head[PIX_BITS]     : 1'b0;
  assign out_sof    = out_valid ? w_head[PIX_BITS+1]   : 1'b0;
  assign row_ready  = r_row_ready;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pixel_row_readout.sv
// Directed bench for pixel_row_readout: latency, tagging, backpressure, drops and mid-row reset.
module tb_pixel_row_readout;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        row_valid;
  logic [0:0]  row_sel;
  logic [15:0] row_data;
  logic        row_ready;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eol;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_count;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Popped entries as {sof, eol, data}.
  logic [9:0] cap_q[$];

  pixel_row_readout #(
    .PIX_BITS(8), .COLS(2), .ROWS(2), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .row_valid(row_valid), .row_sel(row_sel), .row_data(row_data),
    .row_ready(row_ready), .out_data(out_data), .out_sof(out_sof),
    .out_eol(out_eol), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      cap_q.push_back({out_sof, out_eol, out_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_row_ready(input string name);
    int k;
    k = 0;
    while (row_ready !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_tests++;
    if (row_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: row_ready never rose, got %b want 1", name, row_ready);
    end
  endtask

  task automatic send_row(input logic sel, input logic [15:0] dat, input string name);
    wait_row_ready(name);
    row_valid = 1'b1;
    row_sel   = sel;
    row_data  = dat;
    tick();
    row_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_tests++; if (row_ready  !== 1'b1)  begin n_fail++; $display("FAIL reset_row_ready: got %b want 1", row_ready); end
    n_tests++; if (out_valid  !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (fifo_count !== 4'd0)  begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_tests++; if (overflow   !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_tests++; if ({out_sof, out_eol, out_data} !== 10'h000) begin
      n_fail++; $display("FAIL reset_head: got %h want 000", {out_sof, out_eol, out_data});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_row();
    out_ready = 1'b1;
    row_valid = 1'b1; row_sel = 1'b0; row_data = 16'hB2A1;
    tick();
    row_valid = 1'b0;
    n_tests++; if (row_ready !== 1'b0) begin n_fail++; $display("FAIL single_rdy_t0: got %b want 0", row_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_vld_t0: got %b want 0", out_valid); end
    tick();
    n_tests++; if ({out_valid, out_sof, out_eol, out_data} !== {1'b1, 1'b1, 1'b0, 8'hA1}) begin
      n_fail++; $display("FAIL single_px0: got v%b s%b e%b %h want v1 s1 e0 a1", out_valid, out_sof, out_eol, out_data);
    end
    n_tests++; if (row_ready !== 1'b0) begin n_fail++; $display("FAIL single_rdy_t1: got %b want 0", row_ready); end
    tick();
    n_tests++; if ({out_valid, out_sof, out_eol, out_data} !== {1'b1, 1'b0, 1'b1, 8'hB2}) begin
      n_fail++; $display("FAIL single_px1: got v%b s%b e%b %h want v1 s0 e1 b2", out_valid, out_sof, out_eol, out_data);
    end
    n_tests++; if (row_ready !== 1'b1) begin n_fail++; $display("FAIL single_rdy_t2: got %b want 1", row_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp [4];
    exp[0] = {2'b10, 8'h01}; exp[1] = {2'b01, 8'h02};
    exp[2] = {2'b00, 8'h03}; exp[3] = {2'b01, 8'h04};
    out_ready = 1'b1;
    cap_q.delete();
    send_row(1'b0, 16'h0201, "b2b_row0");
    send_row(1'b1, 16'h0403, "b2b_row1");
    repeat (6) tick();
    n_tests++; if (cap_q.size() != 4) begin n_fail++; $display("FAIL b2b_len: got %0d want 4", cap_q.size()); end
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      n_tests++;
      if (cap_q[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_px%0d: got %h want %h", i, cap_q[i], exp[i]); end
    end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    logic [9:0] e;
    out_ready = 1'b0;
    cap_q.delete();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] p0, p1;
      p0 = 8'h10 + 8'(2 * i);
      p1 = p0 + 8'h01;
      send_row(1'(i % 2), {p1, p0}, "bp_row");
    end
    repeat (3) tick();
    n_tests++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL bp_full_count: got %0d want 8", fifo_count); end
    n_tests++; if (row_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_rdy: got %b want 0", row_ready); end
    row_valid = 1'b1; row_sel = 1'b0; row_data = 16'hEEEE;
    tick();
    row_valid = 1'b0;
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (fifo_count !== 4'd7) begin n_fail++; $display("FAIL bp_pop_no_push: got %0d want 7", fifo_count); end
    repeat (20) tick();
    n_tests++; if (cap_q.size() != 10) begin n_fail++; $display("FAIL bp_len: got %0d want 10", cap_q.size()); end
    for (int i = 0; i < 10 && i < cap_q.size(); i++) begin
      e = {((i / 2) % 2 == 0) && (i % 2 == 0), (i % 2 == 1), 8'h10 + 8'(i)};
      n_tests++;
      if (cap_q[i] !== e) begin n_fail++; $display("FAIL bp_px%0d: got %h want %h", i, cap_q[i], e); end
    end
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL bp_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_drop();
    out_ready = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL drop_fs_clear: got %b want 0", overflow); end
    cap_q.delete();
    row_valid = 1'b1; row_sel = 1'b0; row_data = 16'h2221;
    tick();
    row_sel = 1'b1; row_data = 16'h9999;
    tick();
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_set: got %b want 1", overflow); end
    row_data = 16'h8888; frame_start = 1'b1;
    tick();
    row_valid = 1'b0;
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_set_wins: got %b want 1", overflow); end
    n_tests++; if (row_ready !== 1'b1) begin n_fail++; $display("FAIL drop_row_done: got %b want 1", row_ready); end
    tick();
    frame_start = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL drop_fs_clear2: got %b want 0", overflow); end
    repeat (4) tick();
    n_tests++; if (cap_q.size() != 2) begin n_fail++; $display("FAIL drop_len: got %0d want 2", cap_q.size()); end
    if (cap_q.size() >= 2) begin
      n_tests++; if (cap_q[0] !== {2'b10, 8'h21}) begin n_fail++; $display("FAIL drop_px0: got %h want 221", cap_q[0]); end
      n_tests++; if (cap_q[1] !== {2'b01, 8'h22}) begin n_fail++; $display("FAIL drop_px1: got %h want 122", cap_q[1]); end
    end
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b0;
    send_row(1'b0, 16'h4241, "sim_row0");
    send_row(1'b1, 16'h4443, "sim_row1");
    repeat (2) tick();
    n_tests++; if (fifo_count !== 4'd4) begin n_fail++; $display("FAIL sim_fill: got %0d want 4", fifo_count); end
    send_row(1'b0, 16'h4645, "sim_row2");
    out_ready = 1'b1;
    tick();
    n_tests++; if (fifo_count !== 4'd4) begin n_fail++; $display("FAIL sim_push_pop: got %0d want 4", fifo_count); end
    repeat (10) tick();
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL sim_drain: got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_mid_row();
    out_ready = 1'b0;
    send_row(1'b0, 16'h1211, "rst_row0");
    repeat (2) tick();
    send_row(1'b1, 16'h1413, "rst_row1");
    row_valid = 1'b1; row_data = 16'h7777;
    tick();
    row_valid = 1'b0;
    n_tests++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL rst_pre_count: got %0d want 3", fifo_count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ovf: got %b want 1", overflow); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_tests++; if (out_valid  !== 1'b0) begin n_fail++; $display("FAIL rst_mid_vld: got %b want 0", out_valid); end
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", fifo_count); end
    n_tests++; if (row_ready  !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rdy: got %b want 1", row_ready); end
    n_tests++; if (overflow   !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf: got %b want 0", overflow); end
    cap_q.delete();
    out_ready = 1'b1;
    send_row(1'b0, 16'h5566, "rst_post_row");
    repeat (4) tick();
    n_tests++; if (cap_q.size() != 2) begin n_fail++; $display("FAIL rst_post_len: got %0d want 2", cap_q.size()); end
    if (cap_q.size() >= 2) begin
      n_tests++; if (cap_q[0] !== {2'b10, 8'h66}) begin n_fail++; $display("FAIL rst_post_px0: got %h want 266", cap_q[0]); end
      n_tests++; if (cap_q[1] !== {2'b01, 8'h55}) begin n_fail++; $display("FAIL rst_post_px1: got %h want 155", cap_q[1]); end
    end
  endtask

  initial begin
    reset = 1'b0; frame_start = 1'b0; row_valid = 1'b0;
    row_sel = 1'b0; row_data = 16'h0000; out_ready = 1'b0;
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_simul_push_pop();
    test_reset_mid_row();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_row_readout.md
Name: pixel_row_readout

Overview:
- Readout stage directly downstream of the pixel array top level.
- Accepts one row of digitised pixel values at a time (parallel bus) and serialises it column by column into a small tagged FIFO.
- Presents pixels on a valid/ready stream with start-of-frame and end-of-line tags for the off-chip interface.
- The array cannot be stalled, so rows arriving while busy are dropped and flagged.

Parameters:
- PIX_BITS, 8, bits per pixel value from the ramp ADC
- COLS, 2, pixels per row
- ROWS, 2, rows per frame
- FIFO_DEPTH, 8, output FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame
- row_valid  in  1  row_data/row_sel valid this cycle
- row_sel  in  $clog2(ROWS)  index of the presented row
- row_data  in  COLS*PIX_BITS  packed row; column c at bits [c*PIX_BITS +: PIX_BITS]
- row_ready  out  1  block can accept a row this cycle
- out_data  out  PIX_BITS  pixel at FIFO head
- out_sof  out  1  head is row 0, column 0
- out_eol  out  1  head is the last column (COLS-1)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: a row was dropped

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, row_ready=1, out_valid=0, out_sof=0, out_eol=0, out_data=0, fifo_count=0, overflow=0, column counter=0. FIFO contents are discarded. Reset mid-row abandons the row.
- FSM states are IDLE and SHIFT.
  - IDLE: row_ready=1. On row_valid, latch row_data and row_sel into the shift register, set col=0, go to SHIFT.
  - SHIFT: row_ready=0. Each cycle that the FIFO is not full (registered count < FIFO_DEPTH), push {sof,eol,pixel[col]} and increment col.
    - sof = (latched row_sel==0 && col==0).
    - eol = (col==COLS-1).
  - The push of col==COLS-1 returns the FSM to IDLE; row_ready is high the following cycle.
  - FIFO full means no push: the FSM holds with col unchanged. Pixels are never dropped once a row is accepted.
- Latency: row accepted at edge T0; column 0 is pushed at T1 (FIFO not full) and out_valid is high after T1. An unstalled row takes COLS cycles in SHIFT.
- Drop rule: row_valid==1 while row_ready==0 sets overflow=1 and the row is ignored. overflow clears only on reset or frame_start. If frame_start and a drop occur in the same cycle, overflow=1 (set wins).
- frame_start has no effect on the FSM or the FIFO.
- FIFO behaviour:
  - Show-ahead: out_data, out_sof and out_eol reflect the head whenever out_valid=1.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Full check uses the registered count, so there is no pass-through push when full even if a pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
  - When out_valid=0, out_data/out_sof/out_eol hold 0.
- Arithmetic: fifo_count ranges 0..FIFO_DEPTH. col is $clog2(COLS) bits with no wrap beyond COLS-1.

Test Plan:
1. Reset, then a row: row_sel=0, row_data=16'hB2A1, out_ready=1 -> out stream A1 (sof=1, eol=0), then B2 (sof=0, eol=1); out_valid rises one cycle after acceptance; row_ready low for exactly 2 cycles.
2. Back-to-back rows: row_sel=0 (16'h0201) then row_sel=1 (16'h0403), second row_valid held until row_ready=1 -> output 01,02,03,04; only 01 has sof; 02 and 04 have eol; overflow=0.
3. Backpressure: out_ready=0, push 5 rows (10 pixels) with FIFO_DEPTH=8 -> fifo_count saturates at 8; FSM stalls mid-row; row_ready=0; extra row_valid sets overflow=1. Release out_ready -> all 8 queued plus the stalled pixels drain in order with none lost.
4. Drop: row_valid pulsed during SHIFT -> overflow=1 and that row is absent from the output. A frame_start pulse -> overflow=0. frame_start coincident with another drop -> overflow stays 1.
5. Simultaneous push/pop at fifo_count=4 -> count stays 4. At count=8 with out_ready=1 -> pop occurs, no push that cycle, count=7.
6. reset=0 asserted during SHIFT with 3 entries queued -> next cycle out_valid=0, fifo_count=0, row_ready=1, overflow=0. Subsequent row 16'h5566 outputs 66 then 55 correctly.
